// File: rtl/seq_booth_mult_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier
// and its digit encoder.
package seq_booth_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] PP_ZERO = 3'd0;
    localparam logic [2:0] PP_POS1 = 3'd1;
    localparam logic [2:0] PP_POS2 = 3'd2;
    localparam logic [2:0] PP_NEG1 = 3'd3;
    localparam logic [2:0] PP_NEG2 = 3'd4;

    // Counter must hold 0 .. WIDTH/2 with headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width / 2 + 2);
    endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: 3-bit multiplier window plus extended
// multiplicand in, signed partial product (0, +-A, +-2A) out.
module booth_r4_encoder
    import seq_booth_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       window,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp
);

    logic [2:0]       sel;
    logic [WIDTH+2:0] a1;
    logic [WIDTH+2:0] a2;

    always_comb begin
        a1  = {a_ext[WIDTH+1], a_ext};
        a2  = {a_ext, 1'b0};
        sel = PP_ZERO;
        case (window)
            3'b001, 3'b010: sel = PP_POS1;
            3'b011:         sel = PP_POS2;
            3'b100:         sel = PP_NEG2;
            3'b101, 3'b110: sel = PP_NEG1;
            default:        sel = PP_ZERO;
        endcase
        case (sel)
            PP_POS1: pp = a1;
            PP_POS2: pp = a2;
            PP_NEG1: pp = '0 - a1;
            PP_NEG2: pp = '0 - a2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation, fixed
// latency. Define EARLY_TERM_EN to complete zero-operand requests in one cycle.
module seq_booth_mult
    import seq_booth_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [2*WIDTH-1:0] p_out,
    output logic               done,
    output logic               busy
);

    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 2 * WIDTH + 4;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             state_q, state_d;
    logic [WIDTH+1:0]   a_q, a_d;
    logic [WIDTH+2:0]   b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [WIDTH+1:0]   a_ext_in;
    logic [WIDTH+1:0]   b_ext_in;
    logic [WIDTH+2:0]   pp;
    logic [AW-1:0]      pp_ext;
    logic [CW:0]        shamt;
    logic [AW-1:0]      acc_sum;
    logic               zero_op;

    assign a_ext_in = signed_mode ? {{2{a_in[WIDTH-1]}}, a_in} : {2'b00, a_in};
    assign b_ext_in = signed_mode ? {{2{b_in[WIDTH-1]}}, b_in} : {2'b00, b_in};

`ifdef EARLY_TERM_EN
    assign zero_op = (a_in == '0) || (b_in == '0);
`else
    assign zero_op = 1'b0;
`endif

    // b_q carries an appended 0 below bit 0 so the low 3 bits are the current window.
    booth_r4_encoder #(.WIDTH(WIDTH)) u_enc (
        .window (b_q[2:0]),
        .a_ext  (a_q),
        .pp     (pp)
    );

    assign pp_ext  = {{(AW - WIDTH - 3){pp[WIDTH+2]}}, pp};
    assign shamt   = {cnt_q, 1'b0};
    assign acc_sum = acc_q + (pp_ext << shamt);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    if (zero_op) begin
                        state_d = DONE;
                        p_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = CALC;
                        a_d     = a_ext_in;
                        b_d     = {b_ext_in, 1'b0};
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
            end
            CALC: begin
                acc_d = acc_sum;
                b_d   = {2'b00, b_q[WIDTH+2:2]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    p_d     = acc_sum[2*WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign p_out = p_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_seq_booth_mult.sv
// Self-checking bench for seq_booth_mult (WIDTH=16): directed cases plus a
// random regression against an integer-arithmetic product.
module tb_seq_booth_mult;

    localparam int W = 16;

`ifdef EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic [2*W-1:0] p_out;
    logic           done;
    logic           busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_booth_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a_in        (a_in),
        .b_in        (b_in),
        .p_out       (p_out),
        .done        (done),
        .busy        (busy)
    );

    function automatic logic [31:0] ref_mult(input logic [15:0] a, input logic [15:0] b,
                                             input bit sm);
        longint pa;
        longint pb;
        if (sm) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        return 32'(pa * pb);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after an edge; counts cycles until done, checking busy meanwhile.
    task automatic wait_done(input int first, input int max, output int lat);
        lat = first;
        while (done !== 1'b1 && lat < max) begin
            chk("busy_calc", {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit sm,
                          input string tag);
        logic [31:0] exp;
        int lat;
        int exp_lat;
        exp     = ref_mult(a, b, sm);
        exp_lat = (ET && (a == 16'd0 || b == 16'd0)) ? 1 : 10;
        @(negedge clk);
        a_in = a; b_in = b; signed_mode = sm; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, 40, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_p"}, {32'd0, p_out}, {32'd0, exp});
        chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {63'd0, done}, 64'd0);
        chk({tag, "_p_hold"}, {32'd0, p_out}, {32'd0, exp});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nd;
        logic [15:0] ra;
        logic [15:0] rb;
        bit rs;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_p", {32'd0, p_out}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;

        run_op(16'd3, 16'd2, 1'b1, "s3x2");
        chk("tp_6", {32'd0, p_out}, 64'h6);
        run_op(16'd10, 16'hFFFC, 1'b1, "s10xm4");
        chk("tp_m40", {32'd0, p_out}, 64'hFFFFFFD8);
        run_op(16'hFFFB, 16'hFFFB, 1'b1, "sm5xm5");
        chk("tp_25", {32'd0, p_out}, 64'd25);
        run_op(16'h8000, 16'h8000, 1'b1, "smin2");
        chk("tp_minmin", {32'd0, p_out}, 64'h40000000);
        run_op(16'h7FFF, 16'h8000, 1'b1, "smaxmin");
        chk("tp_maxmin", {32'd0, p_out}, 64'hC0008000);
        run_op(16'hFFFF, 16'hFFFF, 1'b0, "umax2");
        chk("tp_umax", {32'd0, p_out}, 64'hFFFE0001);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, "sm1xm1");
        chk("tp_m1m1", {32'd0, p_out}, 64'h1);

        // start while busy is ignored
        @(negedge clk);
        a_in = 16'd3; b_in = 16'd2; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a_in = 16'd7; b_in = 16'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(4, 40, lat);
        chk("ign_lat", 64'(lat), 64'd10);
        chk("ign_p", {32'd0, p_out}, 64'd6);
        nd = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        chk("ign_no_second_done", 64'(nd), 64'd0);
        chk("ign_p_hold_idle", {32'd0, p_out}, 64'd6);

        // start held high through done: back-to-back
        @(negedge clk);
        a_in = 16'd3; b_in = 16'd2; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a_in = 16'd7; b_in = 16'd7;
        wait_done(1, 40, lat);
        chk("b2b_lat1", 64'(lat), 64'd10);
        chk("b2b_p1", {32'd0, p_out}, 64'd6);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_busy2", {63'd0, busy}, 64'd1);
        chk("b2b_done_drop", {63'd0, done}, 64'd0);
        wait_done(1, 40, lat);
        chk("b2b_lat2", 64'(lat), 64'd10);
        chk("b2b_p2", {32'd0, p_out}, 64'd49);
        @(posedge clk); #1;
        chk("b2b_done_end", {63'd0, done}, 64'd0);

        // reset mid-operation
        @(negedge clk);
        a_in = 16'd100; b_in = 16'd100; signed_mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_p", {32'd0, p_out}, 64'd0);
        chk("mid_rst_done", {63'd0, done}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk); rst = 1'b0;
        nd = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done === 1'b1) nd++;
        end
        chk("mid_rst_no_done", 64'(nd), 64'd0);
        chk("mid_rst_idle_busy", {63'd0, busy}, 64'd0);

        run_op(16'd20, 16'd0, 1'b1, "z20x0");
        run_op(16'd0, 16'd1234, 1'b0, "z0x1234");

        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: ra = 16'h0000;
                1: rb = 16'h8000;
                2: ra = 16'hFFFF;
                3: rb = 16'h7FFF;
                4: ra = 16'h8000;
                default: ;
            endcase
            run_op(ra, rb, rs, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
